// File: rtl/sync_burst_sram_pl.sv
// sync_burst_sram_pl
//   Parametrised model of a pipelined synchronous burst SRAM with ADSP/ADSC/ADV
//   control, a 2-bit burst counter, byte-lane writes and registered read data.
//
//   Pipeline:
//     p0: the access decoded on edge N (array read into rd_p0 / array write)
//     p1: output register; DQ_O is valid after edge N+1
//
//   Optional feature macro: SRAM_DCD_EN
//     defined   -> double-cycle deselect (output stays valid one extra edge)
//     undefined -> single-cycle deselect
//
//   Ports:
//     CLK               rising-edge clock
//     RST_N             asynchronous active-low reset (control and output regs)
//     ZZ                sleep: freezes all state, forces DQ_OE low
//     MODE              burst order, 0 = linear, 1 = interleaved
//     ADDR              external address
//     GW_N              global write (all lanes)
//     BWE_N, BW_N       byte-write enable and per-lane strobes (active low)
//     CE1_N, CE2, CE3_N chip enables
//     ADSP_N, ADSC_N    processor / controller address strobes
//     ADV_N             burst advance
//     OE_N              asynchronous output enable
//     DQ_I              write data
//     DQ_O, DQ_OE       read data and its drive enable
module sync_burst_sram_pl #(
  parameter int DATA_W = 18,
  parameter int BYTES  = 2,
  parameter int BYTE_W = 9,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ZZ,
  input  logic              MODE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              GW_N,
  input  logic              BWE_N,
  input  logic [BYTES-1:0]  BW_N,
  input  logic              CE1_N,
  input  logic              CE2,
  input  logic              CE3_N,
  input  logic              ADSP_N,
  input  logic              ADSC_N,
  input  logic              ADV_N,
  input  logic              OE_N,
  input  logic [DATA_W-1:0] DQ_I,
  output logic [DATA_W-1:0] DQ_O,
  output logic              DQ_OE
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] base_p0;
  logic [1:0]        cnt_p0;
  logic              active_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] rd_p0;
  logic [DATA_W-1:0] dq_p1;
  logic              vld_p1;

  logic [ADDR_W-1:0] nxt_base;
  logic [1:0]        nxt_cnt;
  logic              nxt_active;
  logic              acc_rd;
  logic              acc_wr;
  logic              acc_dsel;
  logic [ADDR_W-1:0] acc_addr;
  logic              selected;
  logic              wr_req;
  logic [BYTES-1:0]  wr_lane;

  // Burst address stays inside the aligned 4-word block: only the two low
  // bits are sequenced, bit 2 and above always come from the latched base.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [1:0]        cnt,
                                                   input logic              mode);
    logic [1:0] low;
    low = mode ? (base[1:0] ^ cnt) : (base[1:0] + cnt);
    return {base[ADDR_W-1:2], low};
  endfunction

  assign selected = !CE1_N && CE2 && !CE3_N;
  assign wr_req   = !GW_N || (!BWE_N && (BW_N != {BYTES{1'b1}}));
  assign wr_lane  = {BYTES{acc_wr}} & ({BYTES{!GW_N}} | ({BYTES{!BWE_N}} & ~BW_N));

  // Control decode, priority ADSP > ADSC > ADV/suspend > no-op (ZZ handled at
  // the registers). ADSP is only honoured when CE1_N is low; otherwise the
  // edge is decoded as if ADSP_N were high.
  always_comb begin
    nxt_base   = base_p0;
    nxt_cnt    = cnt_p0;
    nxt_active = active_p0;
    acc_rd     = 1'b0;
    acc_wr     = 1'b0;
    acc_dsel   = 1'b0;
    acc_addr   = burst_addr(base_p0, cnt_p0, MODE);
    if (!ADSP_N && !CE1_N) begin
      if (selected) begin
        nxt_base   = ADDR;
        nxt_cnt    = 2'd0;
        nxt_active = 1'b1;
        acc_addr   = ADDR;
        acc_rd     = 1'b1;
      end else begin
        nxt_active = 1'b0;
        acc_dsel   = 1'b1;
      end
    end else if (!ADSC_N) begin
      if (selected) begin
        nxt_base   = ADDR;
        nxt_cnt    = 2'd0;
        nxt_active = 1'b1;
        acc_addr   = ADDR;
        acc_wr     = wr_req;
        acc_rd     = !wr_req;
      end else begin
        nxt_active = 1'b0;
        acc_dsel   = 1'b1;
      end
    end else if (active_p0) begin
      if (!ADV_N) begin
        nxt_cnt = cnt_p0 + 2'd1;
      end
      acc_addr = burst_addr(base_p0, nxt_cnt, MODE);
      acc_wr   = wr_req;
      acc_rd   = !wr_req;
    end
  end

  // ---- stage p0: control registers ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      base_p0   <= '0;
      cnt_p0    <= '0;
      active_p0 <= 1'b0;
      vld_p0    <= 1'b0;
    end else if (!ZZ) begin
      base_p0   <= nxt_base;
      cnt_p0    <= nxt_cnt;
      active_p0 <= nxt_active;
      vld_p0    <= acc_rd;
    end
  end

  // ---- stage p0: array access (read returns pre-write contents) ----
  always_ff @(posedge CLK) begin
    if (!ZZ) begin
      if (acc_rd) begin
        rd_p0 <= mem[acc_addr];
      end
      for (int b = 0; b < BYTES; b++) begin
        if (wr_lane[b]) begin
          mem[acc_addr][b*BYTE_W +: BYTE_W] <= DQ_I[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // ---- stage p1: output register ----
`ifdef SRAM_DCD_EN
  logic dsel_p0;
  logic ext_p1;

  // A deselect edge lets a valid output live for one extra edge; ext_p1
  // ensures back-to-back deselects extend it only once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dsel_p0 <= 1'b0;
      ext_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      dq_p1   <= '0;
    end else if (!ZZ) begin
      dsel_p0 <= acc_dsel;
      ext_p1  <= dsel_p0 && vld_p1 && !vld_p0 && !ext_p1;
      vld_p1  <= vld_p0 || (dsel_p0 && vld_p1 && !ext_p1);
      if (vld_p0) begin
        dq_p1 <= rd_p0;
      end
    end
  end
`else
  logic unused_dsel;
  assign unused_dsel = acc_dsel;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1 <= 1'b0;
      dq_p1  <= '0;
    end else if (!ZZ) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        dq_p1 <= rd_p0;
      end
    end
  end
`endif

  assign DQ_O  = dq_p1;
  assign DQ_OE = vld_p1 && !OE_N && !ZZ;

endmodule

// File: tb/tb_sync_burst_sram_pl.sv
// Directed testbench for sync_burst_sram_pl (DATA_W=18, ADDR_W=5).
// Honours SRAM_DCD_EN for the deselect-timing expectations.
module tb_sync_burst_sram_pl;

  localparam int DATA_W = 18;
  localparam int BYTES  = 2;
  localparam int BYTE_W = 9;
  localparam int ADDR_W = 5;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              ZZ;
  logic              MODE;
  logic [ADDR_W-1:0] ADDR;
  logic              GW_N;
  logic              BWE_N;
  logic [BYTES-1:0]  BW_N;
  logic              CE1_N;
  logic              CE2;
  logic              CE3_N;
  logic              ADSP_N;
  logic              ADSC_N;
  logic              ADV_N;
  logic              OE_N;
  logic [DATA_W-1:0] DQ_I;
  logic [DATA_W-1:0] DQ_O;
  logic              DQ_OE;

  int compared   = 0;
  int mismatched = 0;

  sync_burst_sram_pl #(
    .DATA_W(DATA_W), .BYTES(BYTES), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ZZ(ZZ), .MODE(MODE), .ADDR(ADDR),
    .GW_N(GW_N), .BWE_N(BWE_N), .BW_N(BW_N),
    .CE1_N(CE1_N), .CE2(CE2), .CE3_N(CE3_N),
    .ADSP_N(ADSP_N), .ADSC_N(ADSC_N), .ADV_N(ADV_N), .OE_N(OE_N),
    .DQ_I(DQ_I), .DQ_O(DQ_O), .DQ_OE(DQ_OE)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    ZZ = 1'b0; ADDR = '0; GW_N = 1'b1; BWE_N = 1'b1; BW_N = '1;
    CE1_N = 1'b0; CE2 = 1'b1; CE3_N = 1'b0;
    ADSP_N = 1'b1; ADSC_N = 1'b1; ADV_N = 1'b1; OE_N = 1'b0; DQ_I = '0;
  endtask

  task automatic write_gw(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ADDR = a; DQ_I = d; GW_N = 1'b0; ADSC_N = 1'b0;
    step();
    idle();
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    idle();
    #1;
    compared++;
    if (DQ_OE !== 1'b0) begin mismatched++; $display("FAIL reset_oe: got %b want 0", DQ_OE); end
    step();
    step();
    compared++;
    if (DQ_O !== 18'h0) begin mismatched++; $display("FAIL reset_dq: got %h want 00000", DQ_O); end
    RST_N = 1'b1;
    step();
    compared++;
    if (DQ_OE !== 1'b0) begin mismatched++; $display("FAIL post_reset_oe: got %b want 0", DQ_OE); end
  endtask

  task automatic test_single;
    write_gw(5'd5, 18'h30F0F);
    ADDR = 5'd5; ADSP_N = 1'b0;
    step();
    idle();
    compared++;
    if (DQ_OE !== 1'b0) begin mismatched++; $display("FAIL single_latency_oe: got %b want 0", DQ_OE); end
    step();
    compared++;
    if (DQ_OE !== 1'b1 || DQ_O !== 18'h30F0F) begin
      mismatched++; $display("FAIL single_read: got oe=%b dq=%h want oe=1 dq=30f0f", DQ_OE, DQ_O);
    end
    OE_N = 1'b1;
    #1;
    compared++;
    if (DQ_OE !== 1'b0) begin mismatched++; $display("FAIL oe_n_gate: got %b want 0", DQ_OE); end
    OE_N = 1'b0;
    #1;
    compared++;
    if (DQ_OE !== 1'b1) begin mismatched++; $display("FAIL oe_n_ungate: got %b want 1", DQ_OE); end
  endtask

  task automatic test_burst(input logic m, input logic [ADDR_W-1:0] start,
                            input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                            input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] e3);
    logic [DATA_W-1:0] exp_q [4];
    exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
    MODE = m; ADDR = start; ADSP_N = 1'b0;
    step();
    ADSP_N = 1'b1; ADDR = '0; ADV_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ADV_N = 1'b1;
      step();
      compared++;
      if (DQ_OE !== 1'b1 || DQ_O !== exp_q[i]) begin
        mismatched++;
        $display("FAIL burst m%0d s%0d beat%0d: got oe=%b dq=%h want oe=1 dq=%h",
                 m, start, i, DQ_OE, DQ_O, exp_q[i]);
      end
    end
    idle();
    MODE = 1'b0;
  endtask

  task automatic test_byte_write;
    write_gw(5'd7, 18'h3FFFF);
    ADDR = 5'd7; ADSC_N = 1'b0; BWE_N = 1'b0; BW_N = 2'b10; DQ_I = '0;
    step();
    idle();
    ADDR = 5'd7; ADSP_N = 1'b0;
    step();
    idle();
    step();
    compared++;
    if (DQ_O !== 18'h3FE00) begin mismatched++; $display("FAIL byte_lane0: got %h want 3fe00", DQ_O); end
    // ADSP with write enables asserted is still a read
    ADDR = 5'd5; ADSP_N = 1'b0; GW_N = 1'b0; DQ_I = '0;
    step();
    idle();
    // ADSC with BWE_N low but no lane strobe is a read
    ADDR = 5'd5; ADSC_N = 1'b0; BWE_N = 1'b0; BW_N = 2'b11; DQ_I = '0;
    step();
    idle();
    compared++;
    if (DQ_O !== 18'h30F0F) begin mismatched++; $display("FAIL adsp_ignores_write: got %h want 30f0f", DQ_O); end
    step();
    compared++;
    if (DQ_O !== 18'h30F0F || DQ_OE !== 1'b1) begin
      mismatched++; $display("FAIL adsc_no_lane_read: got oe=%b dq=%h want oe=1 dq=30f0f", DQ_OE, DQ_O);
    end
  endtask

  task automatic test_adsp_ce1;
    ADDR = 5'd2; ADSP_N = 1'b0;
    step();
    idle();
    ADDR = 5'd0; ADSP_N = 1'b0; CE1_N = 1'b1; ADV_N = 1'b0;
    step();
    idle();
    step();
    compared++;
    if (DQ_OE !== 1'b1 || DQ_O !== 18'd4) begin
      mismatched++; $display("FAIL adsp_ce1_fallthrough: got oe=%b dq=%h want oe=1 dq=00004", DQ_OE, DQ_O);
    end
  endtask

  task automatic test_deselect;
    logic exp_oe;
    ADDR = 5'd0; ADSP_N = 1'b0;
    step();
    idle();
    ADV_N = 1'b0;
    step();
    ADV_N = 1'b1; CE2 = 1'b0; ADSC_N = 1'b0;
    step();
    idle();
    compared++;
    if (DQ_OE !== 1'b1 || DQ_O !== 18'd2) begin
      mismatched++; $display("FAIL dsel_edge: got oe=%b dq=%h want oe=1 dq=00002", DQ_OE, DQ_O);
    end
    step();
`ifdef SRAM_DCD_EN
    exp_oe = 1'b1;
`else
    exp_oe = 1'b0;
`endif
    compared++;
    if (DQ_OE !== exp_oe || DQ_O !== 18'd2) begin
      mismatched++; $display("FAIL dsel_plus1: got oe=%b dq=%h want oe=%b dq=00002", DQ_OE, DQ_O, exp_oe);
    end
    step();
    compared++;
    if (DQ_OE !== 1'b0) begin mismatched++; $display("FAIL dsel_plus2: got %b want 0", DQ_OE); end
  endtask

  task automatic test_zz;
    ADDR = 5'd0; ADSP_N = 1'b0;
    step();
    idle();
    ADV_N = 1'b0;
    step();
    compared++;
    if (DQ_O !== 18'd1 || DQ_OE !== 1'b1) begin
      mismatched++; $display("FAIL zz_pre: got oe=%b dq=%h want oe=1 dq=00001", DQ_OE, DQ_O);
    end
    ZZ = 1'b1;
    #1;
    compared++;
    if (DQ_OE !== 1'b0) begin mismatched++; $display("FAIL zz_comb: got %b want 0", DQ_OE); end
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (DQ_OE !== 1'b0) begin mismatched++; $display("FAIL zz_hold%0d: got %b want 0", i, DQ_OE); end
    end
    ZZ = 1'b0; ADV_N = 1'b1;
    step();
    compared++;
    if (DQ_O !== 18'd2 || DQ_OE !== 1'b1) begin
      mismatched++; $display("FAIL zz_resume: got oe=%b dq=%h want oe=1 dq=00002", DQ_OE, DQ_O);
    end
    step();
    compared++;
    if (DQ_O !== 18'd2) begin mismatched++; $display("FAIL zz_cnt_kept: got %h want 00002", DQ_O); end
    idle();
  endtask

  task automatic test_reset_mid;
    ADDR = 5'd5; ADSP_N = 1'b0;
    step();
    idle();
    step();
    compared++;
    if (DQ_O !== 18'h30F0F || DQ_OE !== 1'b1) begin
      mismatched++; $display("FAIL rst_mid_pre: got oe=%b dq=%h want oe=1 dq=30f0f", DQ_OE, DQ_O);
    end
    RST_N = 1'b0;
    #1;
    compared++;
    if (DQ_OE !== 1'b0 || DQ_O !== 18'h0) begin
      mismatched++; $display("FAIL rst_mid_async: got oe=%b dq=%h want oe=0 dq=00000", DQ_OE, DQ_O);
    end
    #1;
    RST_N = 1'b1;
    ADV_N = 1'b0;
    step();
    step();
    compared++;
    if (DQ_OE !== 1'b0) begin mismatched++; $display("FAIL rst_burst_aborted: got %b want 0", DQ_OE); end
    idle();
    ADDR = 5'd7; ADSP_N = 1'b0;
    step();
    idle();
    step();
    compared++;
    if (DQ_O !== 18'h3FE00 || DQ_OE !== 1'b1) begin
      mismatched++; $display("FAIL rst_array_kept: got oe=%b dq=%h want oe=1 dq=3fe00", DQ_OE, DQ_O);
    end
  endtask

  initial begin
    MODE = 1'b0;
    test_reset();
    test_single();
    write_gw(5'd0, 18'd1);
    write_gw(5'd1, 18'd2);
    write_gw(5'd2, 18'd3);
    write_gw(5'd3, 18'd4);
    test_burst(1'b0, 5'd2, 18'd3, 18'd4, 18'd1, 18'd2);
    test_burst(1'b1, 5'd2, 18'd3, 18'd4, 18'd1, 18'd2);
    test_burst(1'b1, 5'd1, 18'd2, 18'd1, 18'd4, 18'd3);
    test_burst(1'b0, 5'd1, 18'd2, 18'd3, 18'd4, 18'd1);
    test_burst(1'b0, 5'd3, 18'd4, 18'd1, 18'd2, 18'd3);
    test_byte_write();
    test_adsp_ce1();
    test_deselect();
    test_zz();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
